// File: rtl/operand_fetch.sv
// Operand-fetch stage: decodes instruction bytes, holds a 4 x WIDTH register file,
// executes LDI internally and emits a registered operand packet downstream.
module operand_fetch #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [1:0]       op_code,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [1:0]       op_dst,
    output logic             op_valid,
    input  logic             op_ready,
    input  logic             wb_en,
    input  logic [1:0]       wb_addr,
    input  logic [WIDTH-1:0] wb_data
);

    typedef enum logic {
        FETCH = 1'b0,
        IMM   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       ldi_dst_q, ldi_dst_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [1:0]       op_code_q, op_code_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [1:0]       op_dst_q, op_dst_d;
    logic             op_valid_q, op_valid_d;

    logic [1:0]       dec_op, dec_rd, dec_rs;
    logic             accept;

    assign dec_op = instr[7:6];
    assign dec_rd = instr[5:4];
    assign dec_rs = instr[3:2];

    always_comb begin
        instr_ready = 1'b1;
        accept      = 1'b0;
        state_d     = state_q;
        ldi_dst_d   = ldi_dst_q;
        regs_d      = regs_q;
        op_code_d   = op_code_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_dst_d    = op_dst_q;
        op_valid_d  = op_valid_q;

        if (state_q == FETCH) begin
            instr_ready = !op_valid_q || op_ready;
        end
        accept = instr_valid && instr_ready;

        if (op_valid_q && op_ready) begin
            op_valid_d = 1'b0;
        end

        if (wb_en) begin
            regs_d[wb_addr] = wb_data;
        end

        if (accept) begin
            if (state_q == IMM) begin
                // Applied after writeback so the immediate wins a same-register conflict
                regs_d[ldi_dst_q] = WIDTH'(instr);
                state_d           = FETCH;
            end else if (dec_op == 2'b11) begin
                ldi_dst_d = dec_rd;
                state_d   = IMM;
            end else begin
                op_valid_d = 1'b1;
                op_code_d  = dec_op;
                op_dst_d   = dec_rd;
                op_a_d     = (wb_en && wb_addr == dec_rd) ? wb_data : regs_q[dec_rd];
                op_b_d     = (wb_en && wb_addr == dec_rs) ? wb_data : regs_q[dec_rs];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            ldi_dst_q  <= 2'b00;
            op_code_q  <= 2'b00;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_dst_q   <= 2'b00;
            op_valid_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ldi_dst_q  <= ldi_dst_d;
            op_code_q  <= op_code_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_dst_q   <= op_dst_d;
            op_valid_q <= op_valid_d;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign op_code  = op_code_q;
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_dst   = op_dst_q;
    assign op_valid = op_valid_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch: LDI, hold/backpressure,
// streaming, writeback bypass, LDI/writeback conflict and mid-operation reset.
module tb_operand_fetch;

    logic       clk;
    logic       rst;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [1:0] op_code;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [1:0] op_dst;
    logic       op_valid;
    logic       op_ready;
    logic       wb_en;
    logic [1:0] wb_addr;
    logic [7:0] wb_data;

    int compared;
    int mismatched;

    operand_fetch #(.WIDTH(8), .NREGS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .op_code     (op_code),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_dst      (op_dst),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic v, input logic rdy,
                                 input logic we, input logic [1:0] wa, input logic [7:0] wd);
        instr       = b;
        instr_valid = v;
        op_ready    = rdy;
        wb_en       = we;
        wb_addr     = wa;
        wb_data     = wd;
        #1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkPacket(input string tag, input logic [1:0] code, input logic [7:0] a,
                               input logic [7:0] b, input logic [1:0] dst);
        checkOutput({tag, ".valid"}, 8'(op_valid), 8'h01);
        checkOutput({tag, ".code"},  8'(op_code),  8'(code));
        checkOutput({tag, ".a"},     op_a,         a);
        checkOutput({tag, ".b"},     op_b,         b);
        checkOutput({tag, ".dst"},   8'(op_dst),   8'(dst));
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        stepCycle();
        stepCycle();
        checkOutput("rst.valid", 8'(op_valid), 8'h00);
        checkOutput("rst.code",  8'(op_code),  8'h00);
        checkOutput("rst.a",     op_a,         8'h00);
        checkOutput("rst.b",     op_b,         8'h00);
        checkOutput("rst.dst",   8'(op_dst),   8'h00);
        rst = 1'b0;
        #1;
        checkOutput("rst.ready", 8'(instr_ready), 8'h01);

        // LDI R1 <- 5A, LDI R2 <- 0F, then op00 rd1 rs2
        applyStimulus(8'hD0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        stepCycle();
        checkOutput("ldi1.novalid", 8'(op_valid), 8'h00);
        applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        stepCycle();
        applyStimulus(8'hE0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        stepCycle();
        applyStimulus(8'h0F, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        stepCycle();
        checkOutput("ldi2.novalid", 8'(op_valid), 8'h00);
        applyStimulus(8'h18, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        stepCycle();
        checkPacket("alu1", 2'd0, 8'h5A, 8'h0F, 2'd1);

        // Backpressure: next instr waits while packet is held
        applyStimulus(8'h24, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            checkOutput("hold.ready", 8'(instr_ready), 8'h00);
            stepCycle();
            checkPacket("hold", 2'd0, 8'h5A, 8'h0F, 2'd1);
        end
        applyStimulus(8'h24, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        checkOutput("release.ready", 8'(instr_ready), 8'h01);
        stepCycle();
        checkPacket("b2b", 2'd0, 8'h0F, 8'h5A, 2'd2);

        // Four back-to-back ALU ops with downstream always ready
        applyStimulus(8'h44, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        stepCycle();
        checkPacket("s0", 2'd1, 8'h00, 8'h5A, 2'd0);
        applyStimulus(8'h98, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        stepCycle();
        checkPacket("s1", 2'd2, 8'h5A, 8'h0F, 2'd1);
        applyStimulus(8'h2C, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        stepCycle();
        checkPacket("s2", 2'd0, 8'h0F, 8'h00, 2'd2);
        applyStimulus(8'h64, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        stepCycle();
        checkPacket("s3", 2'd1, 8'h0F, 8'h5A, 2'd2);
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
        stepCycle();
        checkOutput("drain.valid", 8'(op_valid), 8'h00);

        // Writeback bypass on both operands, then R2 holds the written value
        applyStimulus(8'h28, 1'b1, 1'b1, 1'b1, 2'd2, 8'hA5);
        stepCycle();
        checkPacket("byp", 2'd0, 8'hA5, 8'hA5, 2'd2);
        applyStimulus(8'h18, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        stepCycle();
        checkPacket("r2", 2'd0, 8'h5A, 8'hA5, 2'd1);

        // LDI R3 with a long gap, immediate collides with writeback to R3
        applyStimulus(8'hF0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        stepCycle();
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("imm.wait.valid", 8'(op_valid), 8'h00);
        end
        applyStimulus(8'h77, 1'b1, 1'b1, 1'b1, 2'd3, 8'h11);
        stepCycle();
        checkOutput("imm.novalid", 8'(op_valid), 8'h00);
        applyStimulus(8'h0C, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        stepCycle();
        checkPacket("conflict", 2'd0, 8'h00, 8'h77, 2'd0);

        // LDI R0 and writeback to R1 on the same edge both land
        applyStimulus(8'hC0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        stepCycle();
        applyStimulus(8'h33, 1'b1, 1'b1, 1'b1, 2'd1, 8'h99);
        stepCycle();
        applyStimulus(8'h04, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        stepCycle();
        checkPacket("dual", 2'd0, 8'h33, 8'h99, 2'd0);

        // Reset while a packet is pending
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        stepCycle();
        checkOutput("pend.valid", 8'(op_valid), 8'h01);
        rst = 1'b1;
        #1;
        checkOutput("pendrst.valid", 8'(op_valid), 8'h00);
        checkOutput("pendrst.a", op_a, 8'h00);
        rst = 1'b0;
        applyStimulus(8'h18, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        stepCycle();
        checkPacket("cleared", 2'd0, 8'h00, 8'h00, 2'd1);

        // Reset while in IMM: next byte must decode as an instruction
        applyStimulus(8'hD0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        stepCycle();
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        checkOutput("imm.ready", 8'(instr_ready), 8'h01);
        rst = 1'b1;
        #1;
        checkOutput("immrst.valid", 8'(op_valid), 8'h00);
        rst = 1'b0;
        applyStimulus(8'h44, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        stepCycle();
        checkPacket("postrst", 2'd1, 8'h00, 8'h00, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Operand-fetch stage of the 8-bit CPU datapath, directly upstream of the operand-select muxes and the XOR/ALU stage.
- Accepts instruction bytes over a valid/ready handshake and holds a 4 x 8-bit register file.
- Decodes each byte and presents a registered operand packet (opcode, A, B, destination) to the downstream stage.
- Executes load-immediate (two-byte) internally and accepts result writeback from downstream.

Parameters:
- WIDTH, 8, data and register width; instruction byte is always 8 bits.
- NREGS, 4, register count; fixed at 4, since the instruction format carries 2-bit register fields.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr  input  8  instruction or immediate byte.
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  stage accepts instr this cycle.
- op_code  output  2  opcode of the emitted packet.
- op_a  output  WIDTH  operand A, R[rd].
- op_b  output  WIDTH  operand B, R[rs].
- op_dst  output  2  destination register for writeback.
- op_valid  output  1  packet valid.
- op_ready  input  1  downstream consumes the packet.
- wb_en  input  1  writeback strobe.
- wb_addr  input  2  writeback register.
- wb_data  input  WIDTH  writeback value.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: R0..R3 = 0x00; op_valid = 0; op_code, op_a, op_b, op_dst = 0; state = FETCH; instr_ready = 1 after reset releases.
- Instruction format: [7:6] op, [5:4] rd, [3:2] rs, [1:0] ignored.
- Ops 00, 01, 10 are ALU ops and produce a packet. Op 11 is LDI: the next accepted byte is the immediate.
- A transfer occurs when instr_valid && instr_ready. A packet transfer occurs when op_valid && op_ready.
- FSM states:
  - FETCH: instr_ready = !op_valid || op_ready.
    - Accepting an ALU op: on the same edge, op_valid <= 1, op_code <= op, op_a <= R[rd], op_b <= R[rs], op_dst <= rd. Latency is 1 cycle from accept to op_valid.
    - Accepting op 11: latch rd into ldi_dst and go to IMM. No packet is emitted.
  - IMM: instr_ready = 1 (independent of op_valid).
    - Accepting a byte: R[ldi_dst] <= instr and return to FETCH.
    - While instr_valid = 0, remain in IMM indefinitely.
- Packet hold: op_valid and all op_* fields are held stable while op_valid && !op_ready.
  - Packet accepted with no new ALU op accepted on that edge: op_valid <= 0.
  - Consume and accept on the same edge: back-to-back packets, op_valid stays 1, so full throughput is 1 packet/cycle.
- Operand read bypass: if wb_en and wb_addr equals rd (or rs) in the accept cycle, wb_data is used for that operand instead of the stale register value. Both operands bypass independently.
- Register write: wb_en writes R[wb_addr] <= wb_data on the edge.
- Write conflict: if an LDI immediate write and wb_en target the same register on the same edge, the LDI value wins (later in program order). Different targets: both writes happen.
- Hazards: RAW hazards against a packet still in flight downstream are not tracked here; the downstream stage or the program handles them.
- Reset mid-operation: asserting rst in IMM or with a pending packet returns to the reset state immediately. The pending packet and the partial LDI are discarded, and registers clear.

Test Plan:
- Reset, then LDI R1 <- 0x5A (bytes 0xD0, 0x5A), then LDI R2 <- 0x0F (0xE0, 0x0F), then instr 0x18 (op 00, rd 1, rs 2) -> one cycle later op_valid = 1, op_code = 00, op_a = 0x5A, op_b = 0x0F, op_dst = 1.
- Hold op_ready = 0 for 3 cycles with instr_valid = 1 -> instr_ready = 0 and the op_* fields stay stable. Raise op_ready -> packet consumed, and the next instr is accepted on the same edge.
- Stream 4 ALU ops with op_ready = 1 continuously -> 4 consecutive op_valid cycles, no bubbles.
- wb_en = 1, wb_addr = 2, wb_data = 0xA5 in the same cycle instr 0x28 (rd 2, rs 2) is accepted -> op_a = op_b = 0xA5, and R2 reads 0xA5 afterward.
- Accept LDI 0xF0 (rd 3) and hold instr_valid = 0 for 5 cycles -> no op_valid. Then byte 0x77 with wb_en = 1, wb_addr = 3, wb_data = 0x11 on the same edge -> R3 = 0x77.
- Assert rst while in IMM with a pending packet -> op_valid drops immediately, registers read 0x00, and the next byte is decoded as an instruction.
